serial_subtractor_16bit: RTL

Bit-serial subtractor computing `a - b - borrow_in` one bit per clock under a start/busy/done handshake. It performs the inverse operation of the combinational 16-bit adder in the arithmetic datapath. It trades latency for area and is driven by a controller that owns operand sequencing. Results are registered and held stable until the next accepted start.

---
 rtl/serial_subtractor_16bit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial subtractor: difference = a - b - borrow_in, one bit per clock, LSB first.
// Define SERIAL_SUB_SIGNED_EN to add the signed overflow output and its operand-MSB flops.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | processing one bit per cycle, busy high
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_subtractor_16bit #(
  parameter int NUM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] difference,
  output logic                underflow
`ifdef SERIAL_SUB_SIGNED_EN
  ,
  output logic                overflow
`endif
);

  localparam int CNT_W = $clog2(NUM_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_BITS-1:0] a_sh;
  logic [NUM_BITS-1:0] b_sh;
  logic [NUM_BITS-1:0] res_sh;
  logic [NUM_BITS-1:0] res_next;
  logic [CNT_W-1:0]    cnt;
  logic                br;
  logic                br_next;
  logic                d;
  logic                ai;
  logic                bi;
  logic                accept;
  logic                last_bit;

`ifdef SERIAL_SUB_SIGNED_EN
  logic a_msb;
  logic b_msb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_BIT) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Full-subtractor cell applied to the current LSBs.
  assign ai       = a_sh[0];
  assign bi       = b_sh[0];
  assign d        = ai ^ bi ^ br;
  assign br_next  = (~ai & bi) | (~(ai ^ bi) & br);
  assign res_next = {d, res_sh[NUM_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      difference <= '0;
      underflow  <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      cnt    <= '0;
      br     <= borrow_in;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      br     <= br_next;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        difference <= res_next;
        underflow  <= br_next;
      end
    end
  end

`ifdef SERIAL_SUB_SIGNED_EN
  // Operand MSBs are shifted out of a_sh/b_sh, so keep copies for the overflow term.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_msb <= a[NUM_BITS-1];
      b_msb <= b[NUM_BITS-1];
    end else if (last_bit) begin
      overflow <= (a_msb ^ b_msb) & (a_msb ^ d);
    end
  end
`endif

endmodule
